// File: rtl/mult_div_unit.sv
// mult_div_unit -- sequential multiply/divide unit holding the HI/LO registers.
//
// Performs MULT/MULTU with a shift-add multiplier and DIV/DIVU with a restoring
// divider. Each operation takes one iteration per clock for WIDTH clocks, then
// one sign-fix clock that writes hi/lo. Divide by zero is reported immediately
// and leaves hi/lo unchanged. MTHI/MTLO load hi/lo directly while idle.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        request an operation (sampled only when idle)
//   op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b         rs / rt operands
//   mthi, mtlo   write a into hi / lo (idle only, start has priority)
//   busy         operation in progress (stall request)
//   done         one-cycle pulse when hi/lo updated or div-by-zero reported
//   div_by_zero  one-cycle pulse with done for DIV/DIVU with b == 0
//   hi, lo       architectural HI / LO registers
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             op_div;
  logic             neg_lo;   // negate product / quotient
  logic             neg_hi;   // negate remainder (sign of dividend)
  logic [WIDTH-1:0] opnd_b;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0] mq;       // multiplier -> low product, or dividend -> quotient
  logic [WIDTH-1:0] acc;      // high product half, or partial remainder

  logic             signed_op;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic             last_iter;

  function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v,
                                               input logic is_signed);
    logic [WIDTH-1:0] r;
    r = v;
    if (is_signed && v[WIDTH-1]) r = -r;
    return r;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v,
                                                   input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                input logic neg);
    return neg ? -v : v;
  endfunction

  always_comb begin
    signed_op = ~op[0];
    mul_sum   = {1'b0, acc} + {1'b0, (mq[0] ? opnd_b : '0)};
    // Restoring step: remainder shifted left with the next dividend bit.
    div_shift = {acc, mq[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_b});
    div_rem   = div_ge ? (div_shift[WIDTH-1:0] - opnd_b) : div_shift[WIDTH-1:0];
    last_iter = (cnt == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      op_div      <= 1'b0;
      neg_lo      <= 1'b0;
      neg_hi      <= 1'b0;
      opnd_b      <= '0;
      mq          <= '0;
      acc         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (op[1] && (b == '0)) begin
              done        <= 1'b1;
              div_by_zero <= 1'b1;
            end else begin
              op_div <= op[1];
              opnd_b <= abs_val(b, signed_op);
              mq     <= abs_val(a, signed_op);
              acc    <= '0;
              cnt    <= '0;
              neg_lo <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_hi <= signed_op & a[WIDTH-1];
              busy   <= 1'b1;
              state  <= op[1] ? S_DIV : S_MUL;
            end
          end else begin
            if (mthi) hi <= a;
            if (mtlo) lo <= a;
          end
        end
        S_MUL: begin
          acc <= mul_sum[WIDTH:1];
          mq  <= {mul_sum[0], mq[WIDTH-1:1]};
          cnt <= cnt + CNT_W'(1);
          if (last_iter) state <= S_FIX;
        end
        S_DIV: begin
          acc <= div_rem;
          mq  <= {mq[WIDTH-2:0], div_ge};
          cnt <= cnt + CNT_W'(1);
          if (last_iter) state <= S_FIX;
        end
        default: begin
          if (op_div) begin
            lo <= cond_neg(mq, neg_lo);
            hi <= cond_neg(acc, neg_hi);
          end else begin
            {hi, lo} <= cond_neg2({acc, mq}, neg_lo);
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: directed vectors with literal expectations plus
// a cycle-level behavioural model compared against the outputs every cycle.
module tb_mult_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Architectural result of an operation as {hi, lo}.
  function automatic logic [63:0] calc(input logic [1:0] o, input logic [31:0] av,
                                       input logic [31:0] bv);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    case (o)
      2'b00: res = sa * sb;
      2'b01: res = {32'b0, av} * {32'b0, bv};
      2'b10: begin
        q = sa / sb;
        r = sa % sb;
        res = {r[31:0], q[31:0]};
      end
      default: res = {av % bv, av / bv};
    endcase
    return res;
  endfunction

  // Behavioural model: operation takes WIDTH+1 edges after the start edge.
  logic        m_busy, m_done, m_dbz;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_res;
  int          m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0;
      m_hi <= '0; m_lo <= '0; m_res <= '0; m_left <= 0;
    end else begin
      m_done <= 1'b0;
      m_dbz  <= 1'b0;
      if (m_left > 0) begin
        if (m_left == 1) begin
          m_hi   <= m_res[63:32];
          m_lo   <= m_res[31:0];
          m_done <= 1'b1;
          m_busy <= 1'b0;
        end
        m_left <= m_left - 1;
      end else if (start) begin
        if (op[1] && b == 32'd0) begin
          m_done <= 1'b1;
          m_dbz  <= 1'b1;
        end else begin
          m_res  <= calc(op, a, b);
          m_left <= 33;
          m_busy <= 1'b1;
        end
      end else begin
        if (mthi) m_hi <= a;
        if (mtlo) m_lo <= a;
      end
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    chk("busy", {31'b0, busy}, {31'b0, m_busy});
    chk("done", {31'b0, done}, {31'b0, m_done});
    chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, m_dbz});
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
  end

  task automatic do_op(input string nm, input logic [1:0] o, input logic [31:0] av,
                       input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el,
                       input int exp_lat, input int exp_busy, input logic exp_dbz);
    int bcnt, lat;
    logic dbz_seen;
    bcnt = 0; lat = 0; dbz_seen = 1'b0;
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) bcnt++;
      if (done) begin
        lat = c;
        dbz_seen = div_by_zero;
        break;
      end
    end
    chk({nm, " latency"}, lat, exp_lat);
    chk({nm, " busy cycles"}, bcnt, exp_busy);
    chk({nm, " dbz flag"}, {31'b0, dbz_seen}, {31'b0, exp_dbz});
    chk({nm, " hi"}, hi, eh);
    chk({nm, " lo"}, lo, el);
  endtask

  initial begin
    int dones, lat;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0; mthi = 1'b0; mtlo = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    rst_n = 1'b1;

    do_op("MULT -3*5", 2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 34, 33, 1'b0);
    do_op("MULTU max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 34, 33, 1'b0);
    do_op("MULT -1*-1", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 34, 33, 1'b0);
    do_op("DIV -7/2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 34, 33, 1'b0);
    do_op("DIVU 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 34, 33, 1'b0);
    do_op("DIV min/-1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34, 33, 1'b0);
    do_op("MULT 0*x", 2'b00, 32'd0, 32'd12345, 32'd0, 32'd0, 34, 33, 1'b0);

    @(negedge clk); mthi = 1'b1; a = 32'h1234;
    @(negedge clk); mthi = 1'b0; mtlo = 1'b1; a = 32'h5678;
    @(negedge clk); mtlo = 1'b0;
    chk("mthi hi", hi, 32'h1234);
    chk("mtlo lo", lo, 32'h5678);

    do_op("DIVU /0", 2'b11, 32'd100, 32'd0, 32'h1234, 32'h5678, 1, 0, 1'b1);

    // MULT 6*7 with a second start and an mtlo while busy; both ignored.
    dones = 0; lat = 0;
    @(negedge clk); start = 1'b1; op = 2'b00; a = 32'd6; b = 32'd7;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 10) begin start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd3; end
      if (c == 12) begin mtlo = 1'b1; a = 32'd77; end
      if (c == 13) mtlo = 1'b0;
      if (done) begin dones++; if (lat == 0) lat = c; end
    end
    chk("busy ignore done count", dones, 32'd1);
    chk("busy ignore latency", lat, 32'd34);
    chk("busy ignore hi", hi, 32'd0);
    chk("busy ignore lo", lo, 32'd42);

    // Asynchronous reset mid-operation.
    @(negedge clk); start = 1'b1; op = 2'b01; a = 32'h10000; b = 32'h10000;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre-reset busy", {31'b0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset busy", {31'b0, busy}, 32'd0);
    chk("async reset done", {31'b0, done}, 32'd0);
    chk("async reset hi", hi, 32'd0);
    chk("async reset lo", lo, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op("DIVU 10/3", 2'b11, 32'd10, 32'd3, 32'd1, 32'd3, 34, 33, 1'b0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
